// File: rtl/tcb_vip_pkg.sv
// Shared types for the TCB transfer recorder: record layout, widths and byte masking.
package tcb_vip_pkg;

    localparam int ADR_W   = 32;
    localparam int DAT_W   = 32;
    localparam int BEN_W   = DAT_W / 8;
    localparam int TSW_W   = 32;
    localparam int DLY_MAX = 4;
    localparam int OVF_W   = 16;

    typedef struct packed {
        logic [TSW_W-1:0] tsp;
        logic             wen;
        logic [ADR_W-1:0] adr;
        logic [BEN_W-1:0] ben;
        logic [DAT_W-1:0] wdt;
        logic [DAT_W-1:0] rdt;
        logic             err;
    } tcb_vip_rec_t;

    function automatic logic [DAT_W-1:0] ben_mask(input logic [DAT_W-1:0] dat,
                                                  input logic [BEN_W-1:0] ben);
        logic [DAT_W-1:0] res;
        res = '0;
        for (int i = 0; i < BEN_W; i++) begin
            if (ben[i]) res[8*i +: 8] = dat[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/tcb_vip_fifo.sv
// Synchronous record FIFO with extra-MSB pointers; a full FIFO still accepts a push when popped in the same cycle.
module tcb_vip_fifo #(
    parameter int  DEP = 16,
    parameter type T   = logic
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic push,
    input  logic pop,
    input  T     din,
    output T     dout,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEP);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    T            mem [DEP];
    logic        do_pop;
    logic        do_push;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clr) mem[wr_ptr[AW-1:0]] <= din;
    end

    // Storage is registered; an empty FIFO presents an all-zero record.
    always_comb begin
        dout = '0;
        if (!empty) dout = mem[rd_ptr[AW-1:0]];
    end

endmodule

// File: rtl/tcb_vip_transfer_recorder.sv
// Passive TCB monitor: pairs each handshake with its response DLY cycles later and queues timestamped records.
module tcb_vip_transfer_recorder
    import tcb_vip_pkg::*;
#(
    parameter int ADR = ADR_W,
    parameter int DAT = DAT_W,
    parameter int DLY = 1,
    parameter int DEP = 16,
    parameter int TSW = TSW_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               tcb_vld,
    input  logic               tcb_rdy,
    input  logic               tcb_wen,
    input  logic [ADR-1:0]     tcb_adr,
    input  logic [DAT/8-1:0]   tcb_ben,
    input  logic [DAT-1:0]     tcb_wdt,
    input  logic [DAT-1:0]     tcb_rdt,
    input  logic               tcb_err,
    output logic               rec_vld,
    input  logic               rec_rdy,
    output tcb_vip_rec_t       rec,
    output logic               ovf,
    output logic [OVF_W-1:0]   ovf_cnt
);

    localparam int DLY_EFF = (DLY > DLY_MAX) ? DLY_MAX : DLY;

    logic [TSW-1:0] tsp_cnt;
    logic           hs;
    tcb_vip_rec_t   req;
    tcb_vip_rec_t   cmp_req;
    tcb_vip_rec_t   rec_in;
    logic           cmp_vld;
    logic           full;
    logic           empty;
    logic           pop_fire;
    logic           drop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tsp_cnt <= '0;
        else        tsp_cnt <= tsp_cnt + 1'b1;
    end

    // An unknown tcb_vld falls into the else path and is not counted as a handshake.
    always_comb begin
        hs = 1'b0;
        if (tcb_vld && tcb_rdy) hs = 1'b1;
    end

    always_comb begin
        req     = '0;
        req.tsp = tsp_cnt;
        req.wen = tcb_wen;
        req.adr = tcb_adr;
        req.ben = tcb_ben;
        req.wdt = tcb_wen ? ben_mask(tcb_wdt, tcb_ben) : '0;
    end

    generate
        if (DLY_EFF == 0) begin : g_bypass
            assign cmp_vld = hs;
            assign cmp_req = req;
        end else begin : g_pipe
            logic         vld_q [DLY_EFF];
            tcb_vip_rec_t req_q [DLY_EFF];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DLY_EFF; i++) begin
                        vld_q[i] <= 1'b0;
                        req_q[i] <= '0;
                    end
                end else begin
                    vld_q[0] <= hs & ~clr;
                    req_q[0] <= req;
                    for (int i = 0; i < DLY_EFF - 1; i++) begin
                        vld_q[i+1] <= vld_q[i] & ~clr;
                        req_q[i+1] <= req_q[i];
                    end
                end
            end

            assign cmp_vld = vld_q[DLY_EFF-1];
            assign cmp_req = req_q[DLY_EFF-1];
        end
    endgenerate

    // The response half of the record is sampled in the completion cycle.
    always_comb begin
        rec_in     = cmp_req;
        rec_in.rdt = cmp_req.wen ? '0 : ben_mask(tcb_rdt, cmp_req.ben);
        rec_in.err = tcb_err;
    end

    tcb_vip_fifo #(
        .DEP (DEP),
        .T   (tcb_vip_rec_t)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .push  (cmp_vld),
        .pop   (rec_rdy),
        .din   (rec_in),
        .dout  (rec),
        .full  (full),
        .empty (empty)
    );

    assign rec_vld  = ~empty;
    assign pop_fire = rec_vld & rec_rdy;
    assign drop     = cmp_vld & full & ~pop_fire & ~clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf     <= 1'b0;
            ovf_cnt <= '0;
        end else if (clr) begin
            ovf     <= 1'b0;
            ovf_cnt <= '0;
        end else if (drop) begin
            ovf <= 1'b1;
            if (ovf_cnt != '1) ovf_cnt <= ovf_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_tcb_vip_transfer_recorder.sv
// Bench for the transfer recorder: three instances (DLY 0/1/2) share one bus and are checked against a queue model.
module tb_tcb_vip_transfer_recorder;
    import tcb_vip_pkg::*;

    localparam int DEP = 16;
    localparam int NI  = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic        tcb_vld = 1'b0;
    logic        tcb_rdy = 1'b0;
    logic        tcb_wen = 1'b0;
    logic [31:0] tcb_adr = '0;
    logic [3:0]  tcb_ben = '0;
    logic [31:0] tcb_wdt = '0;
    logic [31:0] tcb_rdt = '0;
    logic        tcb_err = 1'b0;
    logic        rec_rdy = 1'b0;

    logic         rec_vld_w [NI];
    tcb_vip_rec_t rec_w     [NI];
    logic         ovf_w     [NI];
    logic [15:0]  ovf_cnt_w [NI];

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        tcb_vip_rec_t r;
        int unsigned  due;
    } pend_t;

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] keep_bytes(input logic [31:0] d, input logic [3:0] b);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_inst
        tcb_vip_transfer_recorder #(.DLY(g), .DEP(DEP)) u_dut (
            .clk     (clk),
            .rst_n   (rst_n),
            .clr     (clr),
            .tcb_vld (tcb_vld),
            .tcb_rdy (tcb_rdy),
            .tcb_wen (tcb_wen),
            .tcb_adr (tcb_adr),
            .tcb_ben (tcb_ben),
            .tcb_wdt (tcb_wdt),
            .tcb_rdt (tcb_rdt),
            .tcb_err (tcb_err),
            .rec_vld (rec_vld_w[g]),
            .rec_rdy (rec_rdy),
            .rec     (rec_w[g]),
            .ovf     (ovf_w[g]),
            .ovf_cnt (ovf_cnt_w[g])
        );

        tcb_vip_rec_t fq[$];
        pend_t        pend[$];
        logic         m_ovf;
        logic [15:0]  m_cnt;
        logic [31:0]  m_tsp;

        // Reference: in-flight requests wait in a list until their due cycle, then join the record queue.
        always @(posedge clk or negedge rst_n) begin
            tcb_vip_rec_t req;
            tcb_vip_rec_t done;
            bit           have;
            bit           hs;
            if (!rst_n) begin
                fq.delete();
                pend.delete();
                m_ovf = 1'b0;
                m_cnt = '0;
                m_tsp = '0;
            end else begin
                hs      = (tcb_vld === 1'b1) && (tcb_rdy === 1'b1);
                req     = '0;
                req.tsp = m_tsp;
                req.wen = tcb_wen;
                req.adr = tcb_adr;
                req.ben = tcb_ben;
                req.wdt = tcb_wen ? keep_bytes(tcb_wdt, tcb_ben) : 32'h0;
                done    = '0;
                have    = 1'b0;
                if (clr) begin
                    fq.delete();
                    pend.delete();
                    m_ovf = 1'b0;
                    m_cnt = '0;
                end else begin
                    if (g == 0) begin
                        if (hs) begin
                            done = req;
                            have = 1'b1;
                        end
                    end else if (pend.size() > 0 && pend[0].due == m_tsp) begin
                        done = pend[0].r;
                        pend.delete(0);
                        have = 1'b1;
                    end
                    if (have) begin
                        done.rdt = done.wen ? 32'h0 : keep_bytes(tcb_rdt, done.ben);
                        done.err = tcb_err;
                    end
                    if (fq.size() > 0 && rec_rdy) fq.delete(0);
                    if (have) begin
                        if (fq.size() < DEP) fq.push_back(done);
                        else begin
                            m_ovf = 1'b1;
                            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
                        end
                    end
                    if (g > 0 && hs) pend.push_back('{r: req, due: m_tsp + 32'(g)});
                end
                m_tsp = m_tsp + 32'd1;
            end
        end

        always @(negedge clk) begin
            check($sformatf("rec_vld[%0d]", g), 256'(rec_vld_w[g]), 256'(fq.size() > 0));
            if (fq.size() > 0) check($sformatf("rec[%0d]", g), 256'(rec_w[g]), 256'(fq[0]));
            check($sformatf("ovf[%0d]", g), 256'(ovf_w[g]), 256'(m_ovf));
            check($sformatf("ovf_cnt[%0d]", g), 256'(ovf_cnt_w[g]), 256'(m_cnt));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        tcb_rdt = $urandom;
        tcb_err = 1'($urandom_range(0, 1));
    endtask

    task automatic bus(input logic vld, input logic wen);
        tcb_vld = vld;
        tcb_rdy = 1'b1;
        tcb_wen = wen;
        tcb_adr = $urandom;
        tcb_ben = 4'($urandom_range(0, 15));
        tcb_wdt = $urandom;
    endtask

    task automatic idle_n(input int n);
        tcb_vld = 1'b0;
        repeat (n) step();
    endtask

    task automatic drain();
        rec_rdy = 1'b1;
        idle_n(DEP + 8);
        rec_rdy = 1'b0;
    endtask

    task automatic count_pops(input int k, output int n);
        tcb_vld = 1'b0;
        rec_rdy = 1'b1;
        n = 0;
        for (int i = 0; i < DEP + 8; i++) begin
            @(negedge clk);
            if (rec_vld_w[k]) n++;
            step();
        end
        rec_rdy = 1'b0;
    endtask

    initial begin
        int n;
        // Reset state
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();
        for (int k = 0; k < NI; k++) begin
            check("reset_rec_vld", 256'(rec_vld_w[k]), 256'(1'b0));
            check("reset_ovf", 256'(ovf_w[k]), 256'(1'b0));
            check("reset_ovf_cnt", 256'(ovf_cnt_w[k]), 256'(16'd0));
        end

        // Single masked write, latency DLY+1
        rec_rdy = 1'b0;
        tcb_vld = 1'b1; tcb_rdy = 1'b1; tcb_wen = 1'b1;
        tcb_adr = 32'h10; tcb_ben = 4'b0011; tcb_wdt = 32'hAABBCCDD;
        step();
        tcb_vld = 1'b0;
        step();
        check("wr_rec_vld_dly1", 256'(rec_vld_w[1]), 256'(1'b1));
        check("wr_rec_vld_dly0", 256'(rec_vld_w[0]), 256'(1'b1));
        check("wr_rec_vld_dly2_not_yet", 256'(rec_vld_w[2]), 256'(1'b0));
        check("wr_wen", 256'(rec_w[1].wen), 256'(1'b1));
        check("wr_adr", 256'(rec_w[1].adr), 256'(32'h10));
        check("wr_wdt", 256'(rec_w[1].wdt), 256'(32'h0000CCDD));
        check("wr_rdt", 256'(rec_w[1].rdt), 256'(32'h0));
        drain();

        // Back-to-back reads with rdt 1..4 arriving one cycle after each handshake
        for (int i = 0; i < 4; i++) begin
            bus(1'b1, 1'b0);
            tcb_ben = 4'hF;
            tcb_rdt = 32'(i);
            step();
        end
        tcb_vld = 1'b0;
        tcb_rdt = 32'd4;
        step();
        idle_n(2);
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            check("b2b_rdt", 256'(rec_w[1].rdt), 256'(j + 1));
            check("b2b_wen", 256'(rec_w[1].wen), 256'(1'b0));
            rec_rdy = 1'b1;
        end
        @(negedge clk);
        check("b2b_empty", 256'(rec_vld_w[1]), 256'(1'b0));
        rec_rdy = 1'b0;
        drain();

        // 20 transfers into a stalled FIFO
        for (int i = 0; i < 20; i++) begin
            bus(1'b1, 1'b1);
            step();
        end
        idle_n(4);
        for (int k = 0; k < NI; k++) begin
            check("ovf_set", 256'(ovf_w[k]), 256'(1'b1));
            check("ovf_cnt_4", 256'(ovf_cnt_w[k]), 256'(16'd4));
        end
        count_pops(1, n);
        check("drain_16", 256'(n), 256'(16));
        check("drain_empty", 256'(rec_vld_w[1]), 256'(1'b0));

        // Full FIFO with push and pop in the same cycle
        for (int i = 0; i < DEP; i++) begin
            bus(1'b1, 1'b0);
            step();
        end
        idle_n(4);
        for (int i = 0; i < 5; i++) begin
            bus(1'b1, 1'b0);
            step();
            rec_rdy = 1'b1;
        end
        tcb_vld = 1'b0;
        step();
        rec_rdy = 1'b0;
        idle_n(3);
        check("full_pushpop_ovf_cnt", 256'(ovf_cnt_w[1]), 256'(16'd4));
        count_pops(1, n);
        check("full_pushpop_16", 256'(n), 256'(16));

        // clr with records queued and in flight
        bus(1'b1, 1'b0);
        step();
        bus(1'b1, 1'b1);
        step();
        bus(1'b1, 1'b0);
        clr = 1'b1;
        step();
        clr = 1'b0;
        tcb_vld = 1'b0;
        for (int k = 0; k < NI; k++) begin
            check("clr_rec_vld", 256'(rec_vld_w[k]), 256'(1'b0));
            check("clr_ovf", 256'(ovf_w[k]), 256'(1'b0));
            check("clr_ovf_cnt", 256'(ovf_cnt_w[k]), 256'(16'd0));
        end
        idle_n(4);
        for (int k = 0; k < NI; k++) check("clr_inflight_lost", 256'(rec_vld_w[k]), 256'(1'b0));

        // Random traffic
        for (int i = 0; i < 700; i++) begin
            bus(1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 1)));
            tcb_rdy = 1'($urandom_range(0, 3) != 0);
            rec_rdy = (i < 350) ? 1'($urandom_range(0, 9) < 3) : 1'($urandom_range(0, 9) < 7);
            clr = ($urandom_range(0, 149) == 0);
            step();
        end
        clr = 1'b0;

        // Asynchronous reset in the middle of traffic
        rec_rdy = 1'b0;
        for (int i = 0; i < 20; i++) begin
            bus(1'b1, 1'($urandom_range(0, 1)));
            step();
        end
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < NI; k++) begin
            check("async_rst_rec_vld", 256'(rec_vld_w[k]), 256'(1'b0));
            check("async_rst_ovf", 256'(ovf_w[k]), 256'(1'b0));
            check("async_rst_ovf_cnt", 256'(ovf_cnt_w[k]), 256'(16'd0));
        end
        step();
        step();
        tcb_vld = 1'b0;
        rst_n = 1'b1;
        idle_n(4);
        for (int k = 0; k < NI; k++) check("rst_inflight_lost", 256'(rec_vld_w[k]), 256'(1'b0));

        for (int i = 0; i < 40; i++) begin
            bus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            rec_rdy = 1'($urandom_range(0, 1));
            step();
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
